// File: rtl/booth_mul_pkg.sv
// Shared constants and FSM state type for the radix-4 Booth sequential multiplier.
package booth_mul_pkg;

    localparam int N     = 32;
    localparam int ITER  = 17;
    localparam int PP_W  = 34;
    localparam int ACC_W = 66;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/booth_r4_seq_mul_pp.sv
// Combinational radix-4 Booth partial-product generator: selects 0, +-a or +-2a from a 3-bit window.
module Booth_Algorithm_Norm
    import booth_mul_pkg::*;
(
    input  logic [N-1:0]           i_a,
    input  logic                   i_sign,
    input  logic [2:0]             i_win,
    output logic signed [PP_W-1:0] o_pp
);

    logic signed [PP_W-1:0] w_ax;
    logic signed [PP_W-1:0] w_mag;

    assign w_ax = i_sign ? {{(PP_W-N){i_a[N-1]}}, i_a} : {{(PP_W-N){1'b0}}, i_a};

    always_comb begin
        w_mag = '0;
        case (i_win)
            3'b001, 3'b010, 3'b101, 3'b110: w_mag = w_ax;
            3'b011, 3'b100:                 w_mag = w_ax <<< 1;
            default:                        w_mag = '0;
        endcase
    end

    // Negative groups are one's-complemented here; the +1 is added by the caller.
    assign o_pp = i_win[2] ? ~w_mag : w_mag;

endmodule

// File: rtl/booth_r4_seq_mul.sv
// Sequential 32x32 radix-4 Booth multiplier: one Booth group per cycle, 17 cycles per product,
// valid/ready handshakes on operand and result sides.
module booth_r4_seq_mul
    import booth_mul_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    input  logic             sign,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   product
);

    localparam int P_W = 2 * N;

    state_t                  r_state;
    state_t                  w_next;
    logic [N-1:0]            r_a;
    logic                    r_sign;
    logic [PP_W:0]           r_m;
    logic [4:0]              r_k;
    logic [P_W-1:0]          r_acc;

    logic                    w_ext;
    logic [2:0]              w_win;
    logic signed [PP_W-1:0]  w_pp;
    logic signed [P_W-1:0]   w_pp_ext;
    logic [P_W-1:0]          w_term;
    logic                    w_accept;
    logic                    w_last;

    assign w_ext    = sign & b[N-1];
    assign w_win    = r_m[2:0];
    assign w_accept = (r_state == IDLE) && in_valid;
    assign w_last   = (r_k == 5'(ITER - 1));

    Booth_Algorithm_Norm u_pp (
        .i_a    (r_a),
        .i_sign (r_sign),
        .i_win  (w_win),
        .o_pp   (w_pp)
    );

    // Only the low 64 bits of the 66-bit sum reach product, so accumulation is done modulo 2^64.
    assign w_pp_ext = {{(P_W-PP_W){w_pp[PP_W-1]}}, w_pp};
    assign w_term   = (w_pp_ext + {{(P_W-1){1'b0}}, w_win[2]}) << {r_k, 1'b0};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = RUN;
            end
            RUN: begin
                if (w_last) w_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Multiplier shifts right two bits per group so the active window is always m[2:0].
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a    <= '0;
            r_sign <= 1'b0;
            r_m    <= '0;
            r_k    <= '0;
            r_acc  <= '0;
        end else if (w_accept) begin
            r_a    <= a;
            r_sign <= sign;
            r_m    <= {w_ext, w_ext, b, 1'b0};
            r_k    <= '0;
            r_acc  <= '0;
        end else if (r_state == RUN) begin
            r_acc  <= r_acc + w_term;
            r_m    <= r_m >> 2;
            r_k    <= r_k + 5'd1;
        end
    end

    assign product = r_acc;

endmodule

// File: tb/tb_booth_r4_seq_mul.sv
// Scoreboard bench for booth_r4_seq_mul: driver pushes reference products, negedge monitor pops and compares.
module tb_booth_r4_seq_mul;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        sign = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] product;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic [63:0] sb[$];

    booth_r4_seq_mul dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sign      (sign),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y, input logic s);
        longint sx, sy;
        if (s) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            return 64'(sx * sy);
        end
        return {32'b0, x} * {32'b0, y};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_output", 64'(out_valid), 64'd0);
            end else begin
                check("product", product, sb.pop_front());
            end
        end
    end

    // Offers one operand pair, returns the cycle count at acceptance and the accept-to-out_valid latency.
    task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic s, input bit keep,
                         output int acc_cyc, output int lat);
        int wait_n;
        a = x; b = y; sign = s; in_valid = 1'b1;
        wait_n = 0;
        while (!in_ready && wait_n < 100) begin
            @(posedge clk); #1;
            wait_n++;
        end
        if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        sb.push_back(ref_mul(x, y, s));
        acc_cyc = cyc;
        if (!keep) in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        int acc_c, lat, prev_c, n;
        logic [63:0] held;
        logic [31:0] ra, rb;

        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_product", product, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, acc_c, lat);
        check("latency_umax", 64'(lat), 64'd17);
        check("umax_value", product, 64'hFFFF_FFFE_0000_0001);
        issue(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, acc_c, lat);
        check("latency_smin", 64'(lat), 64'd17);
        issue(32'hFFFF_FFFF, 32'h0000_0003, 1'b1, 1'b0, acc_c, lat);
        issue(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b0, acc_c, lat);
        issue(32'h7FFF_FFFF, 32'h8000_0001, 1'b1, 1'b0, acc_c, lat);

        // Backpressure with an ignored concurrent operand offer
        @(posedge clk); #1;
        out_ready = 1'b0;
        issue(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0, acc_c, lat);
        check("latency_bp", 64'(lat), 64'd17);
        held = product;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; a = $urandom; b = $urandom; sign = 1'b0;
            @(posedge clk); #1;
            check("bp_product_stable", product, held);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_out_valid", 64'(out_valid), 64'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_in_ready", 64'(in_ready), 64'd1);
        check("bp_release_out_valid", 64'(out_valid), 64'd0);

        // Reset during RUN discards the in-flight product
        a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; sign = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        sb.delete();
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_product", product, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        issue(32'd7, 32'd6, 1'b0, 1'b0, acc_c, lat);
        check("after_rst_value", product, 64'd42);

        // Back-to-back random traffic with out_ready tied high
        @(posedge clk); #1;
        prev_c = -1;
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom;
            n = $urandom_range(0, 7);
            if (n == 0) ra = 32'h8000_0000;
            if (n == 1) rb = 32'hFFFF_FFFF;
            issue(ra, rb, 1'($urandom_range(0, 1)), 1'b1, acc_c, lat);
            if (lat != 17) check("b2b_latency", 64'(lat), 64'd17);
            if (prev_c >= 0) check("b2b_spacing", 64'(acc_c - prev_c), 64'd19);
            prev_c = acc_c;
        end
        in_valid = 1'b0;

        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
